// File: rtl/button_event_pkg.sv
// Shared types and helpers for the button event classifier and its prescaler.
// State encodings are fixed so that waveform viewers and debug taps agree
// across builds, whether or not the double-click state is compiled in.
package button_event_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    REPEAT  = 2'd2,
    WAIT2   = 2'd3
  } state_t;

  // Bits needed to hold any value in 0..max_val (never less than one bit).
  function automatic int cnt_width(input int max_val);
    int w;
    w = $clog2(max_val + 1);
    return (w < 1) ? 1 : w;
  endfunction

  // Largest of three thresholds, used to size the shared hold counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider: produces a one-cycle tick every DIV clocks.
// A clear restarts the count so the next tick lands exactly DIV cycles later.
// DIV must be >= 2.
module tick_prescaler
  import button_event_pkg::*;
#(
  parameter int DIV = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int              CNT_W = cnt_width(DIV - 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] r_count;

  // Count 0..DIV-1 and wrap; clear has priority over the wrap.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      r_count <= '0;
    end else if (r_count == LAST) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

  assign tick = (r_count == LAST);

endmodule

// File: rtl/button_event.sv
// Classifies a debounced button level into one-cycle event pulses:
// press, release, long-press, auto-repeat and, when the macro
// BUTTON_EVENT_DOUBLE_CLICK_EN is defined, double-click.
// All timing is counted in prescaled ticks of TICK_DIV clocks.
module button_event
  import button_event_pkg::*;
#(
  parameter int TICK_DIV     = 50000,
  parameter int LONG_TICKS   = 1000,
  parameter int REPEAT_TICKS = 200,
  parameter int DC_TICKS     = 300
) (
  input  logic clk,
  input  logic reset,
  input  logic db,
  output logic press_tick,
  output logic release_tick,
  output logic long_tick,
  output logic repeat_tick,
  output logic double_tick,
  output logic held
);

  localparam int                HOLD_W    = cnt_width(max3(LONG_TICKS, REPEAT_TICKS, DC_TICKS));
  localparam logic [HOLD_W-1:0] LONG_LAST = HOLD_W'(LONG_TICKS - 1);
  localparam logic [HOLD_W-1:0] REP_LAST  = HOLD_W'((REPEAT_TICKS > 0) ? REPEAT_TICKS - 1 : 0);
  localparam bit                REP_EN    = (REPEAT_TICKS > 0);
`ifdef BUTTON_EVENT_DOUBLE_CLICK_EN
  localparam logic [HOLD_W-1:0] DC_LAST   = HOLD_W'((DC_TICKS > 0) ? DC_TICKS - 1 : 0);
`endif

  state_t            r_state, w_state_next;
  logic [HOLD_W-1:0] r_hold, w_hold_next;
  logic              r_db_q;
  logic              w_rise, w_fall, w_tick;
  logic              w_press_next, w_release_next, w_long_next, w_repeat_next, w_double_next;
  logic              r_press, r_release, r_long, r_repeat, r_double, r_held;

  assign w_rise = db & ~r_db_q;
  assign w_fall = ~db & r_db_q;

  // Each rise restarts the tick phase so hold timing is measured from the press.
  tick_prescaler #(.DIV(TICK_DIV)) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .clr   (w_rise),
    .tick  (w_tick)
  );

`ifdef BUTTON_EVENT_DOUBLE_CLICK_EN
  logic r_second, w_second_next;

  // Remembers that the current press is the second half of a double click,
  // so its release returns to IDLE instead of opening another window.
  always_ff @(posedge clk) begin
    if (reset) r_second <= 1'b0;
    else       r_second <= w_second_next;
  end
`endif

  // Next-state logic; a fall always beats a threshold tick in the same cycle.
  always_comb begin
    w_state_next   = r_state;
    w_hold_next    = r_hold;
    w_press_next   = 1'b0;
    w_release_next = 1'b0;
    w_long_next    = 1'b0;
    w_repeat_next  = 1'b0;
    w_double_next  = 1'b0;
`ifdef BUTTON_EVENT_DOUBLE_CLICK_EN
    w_second_next  = r_second;
`endif
    case (r_state)
      IDLE: begin
        if (w_rise) begin
          w_state_next = PRESSED;
          w_hold_next  = '0;
          w_press_next = 1'b1;
`ifdef BUTTON_EVENT_DOUBLE_CLICK_EN
          w_second_next = 1'b0;
`endif
        end
      end
      PRESSED: begin
        if (w_fall) begin
          w_release_next = 1'b1;
          w_hold_next    = '0;
`ifdef BUTTON_EVENT_DOUBLE_CLICK_EN
          w_state_next   = r_second ? IDLE : WAIT2;
          w_second_next  = 1'b0;
`else
          w_state_next   = IDLE;
`endif
        end else if (w_tick) begin
          if (r_hold == LONG_LAST) begin
            w_state_next = REPEAT;
            w_long_next  = 1'b1;
            w_hold_next  = '0;
          end else begin
            w_hold_next  = r_hold + 1'b1;
          end
        end
      end
      REPEAT: begin
        if (w_fall) begin
          w_state_next   = IDLE;
          w_release_next = 1'b1;
          w_hold_next    = '0;
`ifdef BUTTON_EVENT_DOUBLE_CLICK_EN
          w_second_next  = 1'b0;
`endif
        end else if (REP_EN && w_tick) begin
          if (r_hold == REP_LAST) begin
            w_repeat_next = 1'b1;
            w_hold_next   = '0;
          end else begin
            w_hold_next   = r_hold + 1'b1;
          end
        end
      end
`ifdef BUTTON_EVENT_DOUBLE_CLICK_EN
      WAIT2: begin
        if (w_rise) begin
          w_state_next  = PRESSED;
          w_hold_next   = '0;
          w_press_next  = 1'b1;
          w_double_next = 1'b1;
          w_second_next = 1'b1;
        end else if (w_tick) begin
          if (r_hold == DC_LAST) begin
            w_state_next = IDLE;
            w_hold_next  = '0;
          end else begin
            w_hold_next  = r_hold + 1'b1;
          end
        end
      end
`endif
      default: begin
        w_state_next = IDLE;
        w_hold_next  = '0;
      end
    endcase
  end

  // State, edge history and registered event outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_hold    <= '0;
      r_db_q    <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_long    <= 1'b0;
      r_repeat  <= 1'b0;
      r_double  <= 1'b0;
      r_held    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_hold    <= w_hold_next;
      r_db_q    <= db;
      r_press   <= w_press_next;
      r_release <= w_release_next;
      r_long    <= w_long_next;
      r_repeat  <= w_repeat_next;
      r_double  <= w_double_next;
      r_held    <= (w_state_next == PRESSED) || (w_state_next == REPEAT);
    end
  end

  assign press_tick   = r_press;
  assign release_tick = r_release;
  assign long_tick    = r_long;
  assign repeat_tick  = r_repeat;
  assign double_tick  = r_double;
  assign held         = r_held;

endmodule
